// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one
// single-port synchronous memory, with stall back-pressure and a starvation guard.
module mem_port_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_stall,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;

    logic              i_gnt, d_gnt;
    logic              i_sat, d_sat;
    logic              rr_ptr_q, rr_ptr_d;
    logic [3:0]        i_wait_q, i_wait_d;
    logic [3:0]        d_wait_q, d_wait_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_own_q, s1_own_d;
    logic              i_valid_q, i_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    assign i_sat = (i_wait_q == WAIT_MAX);
    assign d_sat = (d_wait_q == WAIT_MAX);

    // A saturated wait counter overrides both priority modes; instruction breaks ties.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (i_req && d_req) begin
                if (i_sat)                i_gnt = 1'b1;
                else if (d_sat)           d_gnt = 1'b1;
                else if (PRIO_MODE == 0)  d_gnt = 1'b1;
                else if (rr_ptr_q == OWN_I) i_gnt = 1'b1;
                else                      d_gnt = 1'b1;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    assign i_stall = i_req & ~i_gnt;
    assign d_stall = d_req & ~d_gnt;

    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (i_gnt)      rr_ptr_d = OWN_D;
        else if (d_gnt) rr_ptr_d = OWN_I;

        i_wait_d = '0;
        if (i_stall) i_wait_d = i_sat ? i_wait_q : i_wait_q + 4'd1;
        d_wait_d = '0;
        if (d_stall) d_wait_d = d_sat ? d_wait_q : d_wait_q + 4'd1;
    end

    // Two-stage read return: owner tagged at grant, data captured one cycle later.
    always_comb begin
        s1_vld_d  = i_gnt | (d_gnt & ~d_we);
        s1_own_d  = d_gnt ? OWN_D : OWN_I;
        i_valid_d = s1_vld_q & (s1_own_q == OWN_I);
        d_valid_d = s1_vld_q & (s1_own_q == OWN_D);
        i_rdata_d = i_valid_d ? mem_rdata : i_rdata_q;
        d_rdata_d = d_valid_d ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= OWN_I;
            i_wait_q  <= '0;
            d_wait_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_own_q  <= OWN_I;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            i_wait_q  <= i_wait_d;
            d_wait_q  <= d_wait_d;
            s1_vld_q  <= s1_vld_d;
            s1_own_q  <= s1_own_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the fixed 16-bit split instruction/data memory path.
- Arbitrates an instruction-fetch port and a data load/store port onto one single-port synchronous memory in the same clock domain.
- Provides stall back-pressure to the pipeline, a selectable arbitration mode, and a starvation guard.
- Sits between the pipeline and the memory in the CPU top.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, address width in bits.
- PRIO_MODE, 0, 0 = data port has fixed priority; 1 = round-robin.
- MAX_WAIT, 4, consecutive stalled cycles of the losing port before it is force-granted; range 1..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  instruction fetch request; held with i_addr while i_stall=1.
- i_addr  input  ADDR_W  fetch address.
- i_stall  output  1  fetch not granted this cycle (combinational).
- i_valid  output  1  one-cycle pulse: i_rdata holds the fetched word.
- i_rdata  output  DATA_W  fetched word; held until the next i_valid.
- d_req  input  1  data request; held with d_we, d_addr and d_wdata while d_stall=1.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_stall  output  1  data request not granted this cycle (combinational).
- d_valid  output  1  one-cycle pulse: d_rdata holds the loaded word. Never pulses for stores.
- d_rdata  output  DATA_W  loaded word; held until the next d_valid.
- mem_en  output  1  memory access enable (combinational).
- mem_we  output  1  memory write enable (combinational).
- mem_addr  output  ADDR_W  memory address (combinational).
- mem_wdata  output  DATA_W  memory write data (combinational).
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - i_valid=0, d_valid=0, i_rdata=0, d_rdata=0.
  - Round-robin pointer = instruction port.
  - Wait counters = 0; pipeline owner registers = none.
  - While reset is low, grants are forced off: mem_en=0, mem_we=0, and i_stall=d_stall=1 when the matching req is high.
- Grant, cycle N, at most one port:
  - Only one requester: that port is granted.
  - Both request, PRIO_MODE=0: data port wins, unless i_wait reached MAX_WAIT, in which case the instruction port wins.
  - Both request, PRIO_MODE=1: the port the pointer names wins. After every granted cycle the pointer moves to the other port.
  - Applies in both modes: a port whose wait counter equals MAX_WAIT wins unconditionally. If both counters are saturated, the instruction port wins.
- Memory drive: mem_en = any grant. mem_we = d_we & data granted. mem_addr and mem_wdata come from the granted port; 0 when idle.
- Stall: x_stall = x_req & ~x_grant. Ports without req have stall=0.
- Wait counters: x_wait increments (saturating at MAX_WAIT) each cycle x_stall=1, and clears on grant or when x_req=0.
- Read pipeline:
  - A grant for a read in cycle N registers owner stage 1.
  - In cycle N+1, mem_rdata is captured into the owner's rdata register at the end of the cycle.
  - x_valid is high in cycle N+2. Latency is fixed at 2 cycles from grant to valid.
- Stores complete at grant: no valid, no rdata change.
- Back-to-back grants to either port are legal every cycle. Up to 2 reads are in flight; responses return in grant order, one per cycle.
- Mid-operation reset discards in-flight reads: no valid pulse after reset is released, and rdata stays 0.
- Width rules:
  - No arithmetic on data or addresses; both pass through unchanged.
  - Counters are 4 bits wide and never wrap.

Test Plan:
- Reset: hold reset=0 with both reqs high -> mem_en=0, i_stall=d_stall=1, all valids and rdata=0. Release reset -> grants begin on the next cycle.
- Single fetch: i_req with i_addr=0x0010 for 1 cycle, memory returns 0xBEEF -> mem_en=1 and mem_addr=0x0010 in cycle N; i_valid=1 with i_rdata=0xBEEF in N+2; d_valid stays 0.
- Fixed priority + starvation, PRIO_MODE=0, MAX_WAIT=4: both reqs held high -> d granted 4 cycles (i_stall=1), i granted cycle 5, d again cycle 6.
- Round-robin, PRIO_MODE=1: both reqs held high 6 cycles -> grants alternate I,D,I,D,I,D; each port sees 3 valids for loads.
- Store then load same address: d_we=1, d_addr=0x0040, d_wdata=0x1234, then a load of 0x0040 -> mem_we=1 only in the first cycle, no d_valid for the store, d_valid with 0x1234 two cycles after the load grant.
- Reset mid-flight: grant a fetch, assert reset in N+1 -> no i_valid ever appears for it, and i_rdata=0.
